// File: rtl/scoreboard_unit_if.sv
// Issue/writeback bundle between decode and the scoreboard interlock.
// master = decode/writeback side driving requests, slave = scoreboard.
// Purely structural; no state.
interface scoreboard_unit_if;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_rs1_used;
  logic        issue_rs2_used;
  logic [4:0]  issue_rd;
  logic        issue_rd_write;
  logic [1:0]  issue_class;
  logic        flush;
  logic        mc_done;
  logic [4:0]  mc_rd;
  logic        stall;
  logic        issue_fire;
  logic        mc_busy;
  logic [31:0] pending_mask;
  logic        mc_timeout;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
           issue_rd, issue_rd_write, issue_class, flush, mc_done, mc_rd,
    input  stall, issue_fire, mc_busy, pending_mask, mc_timeout
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
           issue_rd, issue_rd_write, issue_class, flush, mc_done, mc_rd,
    output stall, issue_fire, mc_busy, pending_mask, mc_timeout
  );
endinterface

// File: rtl/scoreboard_unit.sv
// Issue-stage interlock: load-use bubble, multi-cycle RAW/WAW and structural stalls.
// Latency: stall/issue_fire are combinational (zero-cycle); state updates on next clk edge.
// Backpressure: stall holds decode; SCOREBOARD_BYPASS_EN lets mc_done clears act in the same cycle.
module scoreboard_unit #(
  parameter int MAX_LATENCY = 63
) (
  input  logic              clk,
  input  logic              reset,
  scoreboard_unit_if.slave  sb
);

  localparam logic [1:0] CLS_LOAD = 2'd1;
  localparam logic [1:0] CLS_MC   = 2'd2;
  localparam logic [7:0] AGE_LAST = 8'(MAX_LATENCY - 1);

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

  mc_state_t   r_mc_state;
  mc_state_t   w_mc_state_nxt;
  logic [7:0]  r_age;
  logic [7:0]  w_age_nxt;
  logic [31:0] r_pending;
  logic [31:0] w_pending_nxt;
  logic        r_timeout;
  logic        w_timeout_nxt;
  logic        r_load_v;
  logic [4:0]  r_load_rd;

  logic        w_rs1_live;
  logic        w_rs2_live;
  logic        w_rd_live;
  logic        w_is_load;
  logic        w_is_mc;
  logic        w_mc_busy;
  logic [31:0] w_done_onehot;
  logic [31:0] w_pend_eff;
  logic        w_busy_eff;
  logic        w_load_use;
  logic        w_raw;
  logic        w_waw;
  logic        w_struct;
  logic        w_stall;
  logic        w_fire;
  logic        w_mc_fire;
  logic        w_age_expire;

  // x0 is hardwired, so a zero index never creates a dependency
  assign w_rs1_live = sb.issue_rs1_used & (sb.issue_rs1 != 5'd0);
  assign w_rs2_live = sb.issue_rs2_used & (sb.issue_rs2 != 5'd0);
  assign w_rd_live  = sb.issue_rd_write & (sb.issue_rd != 5'd0);
  assign w_is_load  = (sb.issue_class == CLS_LOAD);
  assign w_is_mc    = (sb.issue_class == CLS_MC);
  assign w_mc_busy  = (r_mc_state == MC_BUSY);

  assign w_done_onehot = sb.mc_done ? (32'd1 << sb.mc_rd) : 32'd0;

`ifdef SCOREBOARD_BYPASS_EN
  // Writeback data is on the forwarding path this cycle, so the retiring
  // register and the unit itself already count as free.
  assign w_pend_eff = r_pending & ~w_done_onehot;
  assign w_busy_eff = w_mc_busy & ~sb.mc_done;
`else
  // Clears only become visible after the edge.
  assign w_pend_eff = r_pending;
  assign w_busy_eff = w_mc_busy;
`endif

  assign w_load_use = r_load_v &
                      ((w_rs1_live & (sb.issue_rs1 == r_load_rd)) |
                       (w_rs2_live & (sb.issue_rs2 == r_load_rd)));
  assign w_raw      = (w_rs1_live & w_pend_eff[sb.issue_rs1]) |
                      (w_rs2_live & w_pend_eff[sb.issue_rs2]);
  assign w_waw      = w_rd_live & w_pend_eff[sb.issue_rd];
  assign w_struct   = w_is_mc & w_busy_eff;

  // Decisions are forced low while reset is held so outputs clear immediately
  assign w_stall   = ~reset & sb.issue_valid & (w_load_use | w_raw | w_waw | w_struct);
  assign w_fire    = ~reset & sb.issue_valid & ~w_stall & ~sb.flush;
  assign w_mc_fire = w_fire & w_is_mc;

  // Expiry only when the op is still outstanding and not retiring this cycle
  assign w_age_expire = w_mc_busy & ~sb.mc_done & (r_age == AGE_LAST);

  // Next-state for the multi-cycle tracker, pending mask, age and sticky timeout
  always_comb begin
    w_mc_state_nxt = r_mc_state;
    w_age_nxt      = r_age;
    w_pending_nxt  = r_pending;
    w_timeout_nxt  = r_timeout;

    case (r_mc_state)
      MC_IDLE: begin
        w_age_nxt = 8'd0;
      end
      MC_BUSY: begin
        if (sb.mc_done) begin
          w_mc_state_nxt = MC_IDLE;
          w_age_nxt      = 8'd0;
        end else if (w_age_expire) begin
          // Abandon the lost op so the pipeline cannot deadlock on it
          w_mc_state_nxt = MC_IDLE;
          w_age_nxt      = 8'd0;
          w_pending_nxt  = 32'd0;
          w_timeout_nxt  = 1'b1;
        end else begin
          w_age_nxt = r_age + 8'd1;
        end
      end
      default: begin
        w_mc_state_nxt = MC_IDLE;
        w_age_nxt      = 8'd0;
      end
    endcase

    // A writeback to a non-pending register clears nothing here
    if (sb.mc_done) begin
      w_pending_nxt = w_pending_nxt & ~w_done_onehot;
    end

    // A new op wins over a same-cycle retire of the same register
    if (w_mc_fire) begin
      w_mc_state_nxt = MC_BUSY;
      w_age_nxt      = 8'd0;
      if (w_rd_live) begin
        w_pending_nxt = w_pending_nxt | (32'd1 << sb.issue_rd);
      end
    end

    w_pending_nxt[0] = 1'b0;
  end

  // State registers for the multi-cycle tracker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mc_state <= MC_IDLE;
      r_age      <= 8'd0;
      r_pending  <= 32'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_mc_state <= w_mc_state_nxt;
      r_age      <= w_age_nxt;
      r_pending  <= w_pending_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // One-cycle load-use window; a flushed or stalled load never opens it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_v  <= 1'b0;
      r_load_rd <= 5'd0;
    end else begin
      r_load_v  <= w_fire & ~sb.flush & w_is_load & w_rd_live;
      r_load_rd <= sb.issue_rd;
    end
  end

  assign sb.stall        = w_stall;
  assign sb.issue_fire   = w_fire;
  assign sb.mc_busy      = w_mc_busy;
  assign sb.pending_mask = r_pending;
  assign sb.mc_timeout   = r_timeout;

endmodule

// File: tb/tb_scoreboard_unit.sv
// Bench for scoreboard_unit: per-scenario tasks with an expectation queue.
// Inputs are driven 1 time unit after posedge, outputs sampled on negedge.
// Two instances: default latency, and MAX_LATENCY=4 for the timeout scenario.
module tb_scoreboard_unit;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [1:0] ALU  = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] MC   = 2'd2;

  typedef struct packed {
    logic        stall;
    logic        fire;
    logic        busy;
    logic        tmo;
    logic [31:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;

  scoreboard_unit_if sb();
  scoreboard_unit_if sb_to();

  scoreboard_unit u_dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  scoreboard_unit #(.MAX_LATENCY(4)) u_dut_to (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_to)
  );

  task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic w, input logic [1:0] cls);
    sb.issue_valid    = v;
    sb.issue_rs1      = rs1;
    sb.issue_rs1_used = u1;
    sb.issue_rs2      = rs2;
    sb.issue_rs2_used = u2;
    sb.issue_rd       = rd;
    sb.issue_rd_write = w;
    sb.issue_class    = cls;
  endtask

  task automatic drv_to(input logic v, input logic [4:0] rd, input logic [1:0] cls);
    sb_to.issue_valid    = v;
    sb_to.issue_rs1      = 5'd0;
    sb_to.issue_rs1_used = 1'b0;
    sb_to.issue_rs2      = 5'd0;
    sb_to.issue_rs2_used = 1'b0;
    sb_to.issue_rd       = rd;
    sb_to.issue_rd_write = 1'b1;
    sb_to.issue_class    = cls;
    sb_to.flush          = 1'b0;
    sb_to.mc_done        = 1'b0;
    sb_to.mc_rd          = 5'd0;
  endtask

  task automatic quiet();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, ALU);
    sb.flush   = 1'b0;
    sb.mc_done = 1'b0;
    sb.mc_rd   = 5'd0;
  endtask

  task automatic exp_push(input logic s, input logic f, input logic b,
                          input logic t, input logic [31:0] m);
    exp_q.push_back(exp_t'{stall: s, fire: f, busy: b, tmo: t, mask: m});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    quiet();
    drv_to(1'b0, 5'd0, ALU);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    quiet();
    drv_to(1'b1, 5'd4, ALU);
    drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, ALU);
    #2;
    exp_push(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    e = exp_q.pop_front();
    n_tests++;
    if ({sb.stall, sb.issue_fire, sb.mc_busy, sb.mc_timeout, sb.pending_mask} !== e) begin
      n_fail++;
      $display("FAIL reset_hold: got s=%b f=%b b=%b t=%b m=%h want all zero",
               sb.stall, sb.issue_fire, sb.mc_busy, sb.mc_timeout, sb.pending_mask);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    quiet();
    drv_to(1'b0, 5'd0, ALU);
    exp_push(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_tests++;
    if ({sb.stall, sb.issue_fire, sb.mc_busy, sb.mc_timeout, sb.pending_mask} !== e) begin
      n_fail++;
      $display("FAIL reset_release: got s=%b f=%b b=%b t=%b m=%h want all zero",
               sb.stall, sb.issue_fire, sb.mc_busy, sb.mc_timeout, sb.pending_mask);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      quiet();
      case (i)
        0:  begin drv(1, 0, 0, 0, 0, 5, 1, LOAD); exp_push(0, 1, 0, 0, 0); end
        1:  begin drv(1, 5, 1, 0, 0, 6, 1, ALU);  exp_push(1, 0, 0, 0, 0); end
        2:  begin drv(1, 5, 1, 0, 0, 6, 1, ALU);  exp_push(0, 1, 0, 0, 0); end
        3:  begin drv(1, 0, 0, 0, 0, 5, 1, LOAD); exp_push(0, 1, 0, 0, 0); end
        4:  begin drv(1, 0, 1, 5, 0, 6, 1, ALU);  exp_push(0, 1, 0, 0, 0); end
        5:  begin drv(1, 0, 0, 0, 0, 0, 1, LOAD); exp_push(0, 1, 0, 0, 0); end
        6:  begin drv(1, 0, 1, 0, 1, 6, 1, ALU);  exp_push(0, 1, 0, 0, 0); end
        7:  begin drv(1, 0, 0, 0, 0, 5, 1, LOAD); exp_push(0, 1, 0, 0, 0); end
        8:  begin drv(0, 5, 1, 5, 1, 6, 1, ALU);  exp_push(0, 0, 0, 0, 0); end
        9:  begin drv(1, 5, 1, 0, 0, 6, 1, ALU);  exp_push(0, 1, 0, 0, 0); end
        10: begin drv(1, 0, 0, 0, 0, 5, 0, LOAD); exp_push(0, 1, 0, 0, 0); end
        default: begin drv(1, 0, 0, 5, 1, 6, 1, ALU); exp_push(0, 1, 0, 0, 0); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if ({sb.stall, sb.issue_fire, sb.mc_busy, sb.mc_timeout, sb.pending_mask} !== e) begin
        n_fail++;
        $display("FAIL load_use step %0d: got s=%b f=%b b=%b t=%b m=%h want s=%b f=%b b=%b t=%b m=%h",
                 i, sb.stall, sb.issue_fire, sb.mc_busy, sb.mc_timeout, sb.pending_mask,
                 e.stall, e.fire, e.busy, e.tmo, e.mask);
      end
    end
  endtask

  task automatic test_mc_raw();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      quiet();
      if (i == 0) begin
        drv(1, 0, 0, 0, 0, 7, 1, MC);
        exp_push(0, 1, 0, 0, 0);
      end else if (i < 10) begin
        drv(1, 7, 1, 0, 0, 10, 1, ALU);
        exp_push(1, 0, 1, 0, 32'h80);
      end else if (i == 10) begin
        drv(1, 7, 1, 0, 0, 10, 1, ALU);
        sb.mc_done = 1'b1;
        sb.mc_rd   = 5'd7;
        exp_push(!BYPASS, BYPASS, 1, 0, 32'h80);
      end else if (i == 11) begin
        drv(!BYPASS, 7, 1, 0, 0, 10, 1, ALU);
        exp_push(0, !BYPASS, 0, 0, 0);
      end else begin
        exp_push(0, 0, 0, 0, 0);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if ({sb.stall, sb.issue_fire, sb.mc_busy, sb.mc_timeout, sb.pending_mask} !== e) begin
        n_fail++;
        $display("FAIL mc_raw step %0d: got s=%b f=%b b=%b t=%b m=%h want s=%b f=%b b=%b t=%b m=%h",
                 i, sb.stall, sb.issue_fire, sb.mc_busy, sb.mc_timeout, sb.pending_mask,
                 e.stall, e.fire, e.busy, e.tmo, e.mask);
      end
    end
  endtask

  task automatic test_struct_waw();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      quiet();
      case (i)
        0: begin drv(1, 0, 0, 0, 0, 7, 1, MC);   exp_push(0, 1, 0, 0, 0); end
        1: begin drv(1, 0, 0, 0, 0, 12, 1, MC);  exp_push(1, 0, 1, 0, 32'h80); end
        2: begin drv(1, 0, 0, 0, 0, 7, 1, ALU);  exp_push(1, 0, 1, 0, 32'h80); end
        3: begin drv(1, 0, 0, 0, 0, 8, 1, ALU);  exp_push(0, 1, 1, 0, 32'h80); end
        4: begin drv(1, 0, 0, 0, 0, 7, 0, ALU);  exp_push(0, 1, 1, 0, 32'h80); end
        5: begin
          drv(1, 0, 0, 0, 0, 7, 1, MC);
          sb.mc_done = 1'b1;
          sb.mc_rd   = 5'd7;
          exp_push(!BYPASS, BYPASS, 1, 0, 32'h80);
        end
        6: begin
          drv(!BYPASS, 0, 0, 0, 0, 7, 1, MC);
          if (BYPASS) exp_push(0, 0, 1, 0, 32'h80);
          else        exp_push(0, 1, 0, 0, 32'h0);
        end
        7: begin exp_push(0, 0, 1, 0, 32'h80); end
        8: begin sb.mc_done = 1'b1; sb.mc_rd = 5'd7; exp_push(0, 0, 1, 0, 32'h80); end
        default: begin exp_push(0, 0, 0, 0, 0); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if ({sb.stall, sb.issue_fire, sb.mc_busy, sb.mc_timeout, sb.pending_mask} !== e) begin
        n_fail++;
        $display("FAIL struct_waw step %0d: got s=%b f=%b b=%b t=%b m=%h want s=%b f=%b b=%b t=%b m=%h",
                 i, sb.stall, sb.issue_fire, sb.mc_busy, sb.mc_timeout, sb.pending_mask,
                 e.stall, e.fire, e.busy, e.tmo, e.mask);
      end
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      quiet();
      case (i)
        0: begin drv(1, 0, 0, 0, 0, 9, 1, MC); exp_push(0, 1, 0, 0, 0); end
        1: begin exp_push(0, 0, 1, 0, 32'h200); end
        2: begin
          drv(1, 0, 0, 0, 0, 9, 1, MC);
          sb.mc_done = 1'b1;
          sb.mc_rd   = 5'd9;
          exp_push(!BYPASS, BYPASS, 1, 0, 32'h200);
        end
        3: begin
          drv(!BYPASS, 0, 0, 0, 0, 9, 1, MC);
          if (BYPASS) exp_push(0, 0, 1, 0, 32'h200);
          else        exp_push(0, 1, 0, 0, 32'h0);
        end
        4: begin exp_push(0, 0, 1, 0, 32'h200); end
        5: begin sb.mc_done = 1'b1; sb.mc_rd = 5'd4; exp_push(0, 0, 1, 0, 32'h200); end
        6: begin exp_push(0, 0, 0, 0, 32'h200); end
        7: begin sb.mc_done = 1'b1; sb.mc_rd = 5'd9; exp_push(0, 0, 0, 0, 32'h200); end
        default: begin exp_push(0, 0, 0, 0, 0); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if ({sb.stall, sb.issue_fire, sb.mc_busy, sb.mc_timeout, sb.pending_mask} !== e) begin
        n_fail++;
        $display("FAIL same_cycle step %0d: got s=%b f=%b b=%b t=%b m=%h want s=%b f=%b b=%b t=%b m=%h",
                 i, sb.stall, sb.issue_fire, sb.mc_busy, sb.mc_timeout, sb.pending_mask,
                 e.stall, e.fire, e.busy, e.tmo, e.mask);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      quiet();
      case (i)
        0: begin drv(1, 0, 0, 0, 0, 5, 1, LOAD); exp_push(0, 1, 0, 0, 0); end
        1: begin drv(1, 5, 1, 0, 0, 6, 1, ALU); sb.flush = 1'b1; exp_push(1, 0, 0, 0, 0); end
        2: begin drv(1, 5, 1, 0, 0, 6, 1, ALU); exp_push(0, 1, 0, 0, 0); end
        3: begin drv(1, 0, 0, 0, 0, 8, 1, ALU); sb.flush = 1'b1; exp_push(0, 0, 0, 0, 0); end
        4: begin drv(1, 0, 0, 0, 0, 7, 1, MC);  sb.flush = 1'b1; exp_push(0, 0, 0, 0, 0); end
        5: begin exp_push(0, 0, 0, 0, 0); end
        6: begin drv(1, 0, 0, 0, 0, 7, 1, MC); exp_push(0, 1, 0, 0, 0); end
        7: begin sb.flush = 1'b1; exp_push(0, 0, 1, 0, 32'h80); end
        default: begin exp_push(0, 0, 1, 0, 32'h80); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if ({sb.stall, sb.issue_fire, sb.mc_busy, sb.mc_timeout, sb.pending_mask} !== e) begin
        n_fail++;
        $display("FAIL flush step %0d: got s=%b f=%b b=%b t=%b m=%h want s=%b f=%b b=%b t=%b m=%h",
                 i, sb.stall, sb.issue_fire, sb.mc_busy, sb.mc_timeout, sb.pending_mask,
                 e.stall, e.fire, e.busy, e.tmo, e.mask);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      quiet();
      case (i)
        0: begin drv(1, 0, 0, 0, 0, 7, 1, MC); exp_push(0, 1, 0, 0, 0); end
        1: begin exp_push(0, 0, 1, 0, 32'h80); end
        2: begin sb.mc_done = 1'b1; sb.mc_rd = 5'd4; exp_push(0, 0, 1, 0, 32'h80); end
        3: begin drv(1, 0, 0, 0, 0, 3, 1, MC); exp_push(0, 1, 0, 0, 32'h80); end
        4: begin exp_push(0, 0, 1, 0, 32'h88); end
        default: begin
          // reset lands mid-cycle with a live, hazard-free instruction in decode
          drv(1, 0, 0, 0, 0, 8, 1, ALU);
          reset = 1'b1;
          #2;
          exp_push(0, 0, 0, 0, 0);
        end
      endcase
      if (i < 5) @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if ({sb.stall, sb.issue_fire, sb.mc_busy, sb.mc_timeout, sb.pending_mask} !== e) begin
        n_fail++;
        $display("FAIL reset_mid step %0d: got s=%b f=%b b=%b t=%b m=%h want s=%b f=%b b=%b t=%b m=%h",
                 i, sb.stall, sb.issue_fire, sb.mc_busy, sb.mc_timeout, sb.pending_mask,
                 e.stall, e.fire, e.busy, e.tmo, e.mask);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    quiet();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      drv_to(1'b0, 5'd0, ALU);
      if (i == 0) begin
        drv_to(1'b1, 5'd3, MC);
        exp_push(0, 1, 0, 0, 0);
      end else if (i < 5) begin
        exp_push(0, 0, 1, 0, 32'h8);
      end else if (i == 5) begin
        exp_push(0, 0, 0, 1, 32'h0);
      end else if (i == 6) begin
        drv_to(1'b1, 5'd3, MC);
        exp_push(0, 1, 0, 1, 32'h0);
      end else begin
        exp_push(0, 0, 1, 1, 32'h8);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if ({sb_to.stall, sb_to.issue_fire, sb_to.mc_busy, sb_to.mc_timeout, sb_to.pending_mask} !== e) begin
        n_fail++;
        $display("FAIL timeout step %0d: got s=%b f=%b b=%b t=%b m=%h want s=%b f=%b b=%b t=%b m=%h",
                 i, sb_to.stall, sb_to.issue_fire, sb_to.mc_busy, sb_to.mc_timeout, sb_to.pending_mask,
                 e.stall, e.fire, e.busy, e.tmo, e.mask);
      end
    end
    do_reset();
    exp_push(0, 0, 0, 0, 0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_tests++;
    if ({sb_to.stall, sb_to.issue_fire, sb_to.mc_busy, sb_to.mc_timeout, sb_to.pending_mask} !== e) begin
      n_fail++;
      $display("FAIL timeout_cleared: got b=%b t=%b m=%h want all zero",
               sb_to.mc_busy, sb_to.mc_timeout, sb_to.pending_mask);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_mc_raw();
    test_struct_waw();
    test_same_cycle();
    test_flush();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scoreboard_unit.md
# scoreboard_unit

Issue-stage interlock that decides when the instruction in decode must stall because the execute/memory forwarding network cannot yet supply an operand. It tracks a one-cycle load-use window and per-register pending writes from the single long-latency (multi-cycle) execution unit, and it enforces the one-outstanding-multi-cycle-op rule. It sits directly upstream of the operand forwarding muxes. Once it releases an instruction, every source value is either in the register file or available on a forwarding path.

## Interface
- MAX_LATENCY, 63, maximum cycles a multi-cycle op may stay outstanding before timeout; 2..255
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- issue_valid  in  1  decode holds a valid instruction
- issue_rs1, issue_rs2  in  5  source register indices
- issue_rs1_used, issue_rs2_used  in  1  source is actually read
- issue_rd  in  5  destination index
- issue_rd_write  in  1  instruction writes issue_rd
- issue_class  in  2  0 = ALU, 1 = LOAD, 2 = MULTICYCLE, 3 = treated as ALU
- flush  in  1  pipeline redirect; kills the decode instruction this cycle
- mc_done  in  1  multi-cycle unit writes back this cycle
- mc_rd  in  5  multi-cycle writeback destination
- stall  out  1  hold decode/fetch (combinational)
- issue_fire  out  1  issue_valid & ~stall & ~flush
- mc_busy  out  1  a multi-cycle op is outstanding
- pending_mask  out  32  bit i = register i awaiting multi-cycle writeback; bit 0 is always 0
- mc_timeout  out  1  sticky error: outstanding op exceeded MAX_LATENCY

## Operation
- A source is live when its used flag is 1 and its index is non-zero. Register x0 never causes a hazard.
- Load-use: register load_rd/load_v is loaded every cycle with issue_rd and (issue_fire & class==LOAD & issue_rd_write & rd!=0). stall=1 if load_v and any live source == load_rd. Result: exactly one bubble.
- RAW on multi-cycle: stall=1 if any live source has pending_mask bit set.
- WAW: stall=1 if issue_rd_write, rd!=0, and pending_mask[rd]=1.
- Structural: stall=1 if class==MULTICYCLE and mc_busy.
- stall is only asserted while issue_valid=1.
- On issue_fire with class==MULTICYCLE: mc_busy←1, age counter←0. If rd_write and rd!=0, pending_mask[rd]←1.
- mc_done: clears pending_mask[mc_rd] and mc_busy. If mc_rd is not pending, the event is ignored apart from clearing mc_busy.
- Age counter increments each cycle while mc_busy. When it reaches MAX_LATENCY with no mc_done: mc_timeout←1 (sticky until reset), pending_mask←0, mc_busy←0.
- flush: forces issue_fire=0 and clears load_v on the next edge. It does not touch pending_mask or mc_busy, because the outstanding op is older than the flush point.
- Same-cycle mc_done and issue_fire of a new MULTICYCLE op: the set takes priority over the clear on the same register, and mc_busy stays 1.

## Timing
- stall and issue_fire are purely combinational from inputs and registered state. Zero-cycle decision.
- State updates on the rising clk edge following the event.
- The load-use stall lasts exactly 1 cycle. A multi-cycle dependency stall lasts until mc_done (see Configuration).
- Reset values: stall=0, issue_fire=0, mc_busy=0, pending_mask=0, mc_timeout=0, load_v=0, age=0.
- When reset asserts mid-operation, all pending state is discarded immediately and asynchronously.

## Configuration
- SCOREBOARD_BYPASS_EN defined:
  - In a cycle with mc_done=1, pending_mask[mc_rd] and mc_busy are treated as already clear in the stall equations.
  - A dependent instruction issues in the writeback cycle, with its data taken from the forwarding path.
  - A new MULTICYCLE op may issue in the mc_done cycle.
- Undefined: clears take effect only after the edge. Dependents and new MULTICYCLE ops stall one extra cycle.

## Test plan
- Load-use bubble:
  - Stimulus: LOAD rd=5 fires, then ADD with rs1=5 is valid.
  - Required: stall=1 for 1 cycle, then issue_fire=1.
  - Repeat with rs1=0 and rd=0: no stall.
- Multi-cycle RAW:
  - Stimulus: MULTICYCLE rd=7 fires, dependent reading x7 is valid, mc_done with mc_rd=7 arrives 10 cycles later.
  - Required: pending_mask=0x80 and stall=1 until mc_done. issue_fire coincides with mc_done with SCOREBOARD_BYPASS_EN, one cycle later without.
- Structural and WAW:
  - Stimulus: second MULTICYCLE op while mc_busy; separately, an ALU op with rd=7 while x7 is pending.
  - Required: both stall.
  - Stimulus: an ALU op with rd=8.
  - Required: it issues.
- Timeout:
  - Stimulus: MAX_LATENCY=4, MULTICYCLE rd=3, no mc_done.
  - Required: mc_timeout=1 after 4 busy cycles, with pending_mask=0 and mc_busy=0. mc_timeout stays 1 until reset.
- Flush and reset:
  - Stimulus: flush in the cycle after a LOAD fires.
  - Required: issue_fire=0 that cycle, and the next instruction is not stalled by the load.
  - Stimulus: reset asserted with pending_mask=0x88.
  - Required: all outputs go to 0 immediately.
- Same-cycle set/clear:
  - Stimulus: mc_done with mc_rd=9 while a new MULTICYCLE op with rd=9 fires (bypass build).
  - Required: pending_mask[9]=1 and mc_busy=1 afterwards.
